// File: rtl/euler_pkg.sv
// euler_pkg: shared widths, Q8.8 limits and FSM states for the Euler solver stages
package euler_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int CNT_W = 8;
  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/sat_add.sv
// sat_add: signed saturating adder with saturation flag
module sat_add import euler_pkg::*; #(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);
  logic [W:0] s;
  always_comb begin
    s = {a[W-1], a} + {b[W-1], b};
    sat = s[W] ^ s[W-1];
    sum = sat ? {s[W], {(W-1){~s[W]}}} : s[W-1:0];
  end
endmodule

// File: rtl/euler_accumulator.sv
// euler_accumulator: counted saturating Q8.8 accumulator with sticky overflow
module euler_accumulator #(
  parameter int DATA_W = euler_pkg::DATA_W,
  parameter int CNT_W = euler_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_init,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_product,
  input  logic              i_overflow,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_result,
  output logic [CNT_W-1:0]  o_step,
  output logic              o_done,
  output logic              o_overflow
);
  import euler_pkg::*;
  state_t state, state_n;
  logic [DATA_W-1:0] acc, sum;
  logic [CNT_W-1:0] step, cnt, step_inc;
  logic ovf, sat, accept, load;
  sat_add #(.W(DATA_W)) u_sat (.a(acc), .b(i_product), .sum(sum), .sat(sat));
  always_comb begin
    o_ready = state == ACCUM;
    accept = i_valid && o_ready;
    load = i_start && !o_ready;
    step_inc = step + CNT_W'(1);
    state_n = load ? (i_count == '0 ? DONE : ACCUM) : (accept && step_inc == cnt) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      step <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        acc <= i_init;
        step <= '0;
        cnt <= i_count;
        ovf <= 1'b0;
      end else if (accept) begin
        acc <= sum;
        step <= step_inc;
        ovf <= ovf | i_overflow | sat;
      end
    end
  end
  assign o_result = acc;
  assign o_step = step;
  assign o_done = state == DONE;
  assign o_overflow = ovf;
endmodule
